// File: rtl/dac_sched_pkg.sv
// Shared definitions for the AD5676 channel-update scheduler.
//   CMD_WR_UPD : write input register and update DAC output at once
//   CMD_WR_IN  : write input register only, output changes on LDAC
//   state_e    : scheduler FSM states
//   FRAME_W    : width of one frame handed to the serializer
package dac_sched_pkg;

   localparam int FRAME_W = 24;

   localparam logic [3:0] CMD_WR_UPD = 4'b0011;
   localparam logic [3:0] CMD_WR_IN  = 4'b0001;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      SEND  = 3'd2,
      WAIT  = 3'd3,
      LDAC  = 3'd4
   } state_e;

endpackage

// File: rtl/rr_arbiter_6.sv
// Combinational round-robin arbiter.
//   eligible : request mask that may be granted this cycle
//   ptr      : first index to consider; search wraps past N-1 back to 0
//   grant    : one-hot grant (all zero when nothing is eligible)
//   idx      : binary index of the granted requester
//   valid    : high when a grant was found
module rr_arbiter_6 #(
   parameter int N  = 6,
   parameter int IW = 3
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW:0]   sum;
   logic [IW-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      sum   = '0;
      cand  = '0;
      // Walk the ring starting at ptr; the first eligible hit wins.
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         cand = sum[IW-1:0];
         if (!valid && eligible[cand]) begin
            valid       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/dac_ch_scheduler.sv
// Schedules NUM_CH channel-update requesters onto one AD5676 frame sender.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   sync_mode          : 0 = write+update per frame, 1 = batch then LDAC
//   req / code / ack   : per-channel level request, 16-bit code, grant pulse
//   frame_valid/_data/_ready : 24-bit frame handshake to the serializer
//   frame_done         : serializer finished shifting the accepted frame
//   ldac_n             : AD5676 LDAC pin (active low)
//   busy               : scheduler is not in IDLE
module dac_ch_scheduler
   import dac_sched_pkg::*;
#(
   parameter int NUM_CH      = 6,
   parameter int LDAC_CYCLES = 4
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 sync_mode,
   input  logic [NUM_CH-1:0]    req,
   input  logic [16*NUM_CH-1:0] code,
   output logic [NUM_CH-1:0]    ack,
   output logic                 frame_valid,
   output logic [FRAME_W-1:0]   frame_data,
   input  logic                 frame_ready,
   input  logic                 frame_done,
   output logic                 ldac_n,
   output logic                 busy
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [NUM_CH-1:0]    mask_q, mask_d;
   logic                 sync_q, sync_d;
   logic [NUM_CH-1:0]    ack_q, ack_d;
   logic                 frame_valid_q, frame_valid_d;
   logic [FRAME_W-1:0]   frame_data_q, frame_data_d;
   logic [3:0]           ldac_cnt_q, ldac_cnt_d;

   logic [15:0]          code_arr [NUM_CH];
   logic [NUM_CH-1:0]    eligible;
   logic [NUM_CH-1:0]    arb_grant;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_valid;
   logic [3:0]           cmd;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_code
      assign code_arr[gi] = code[16*gi +: 16];
   end

   // In sync mode only the snapshot taken in IDLE may be served, so late
   // requesters fall through to the next batch.
   assign eligible = sync_q ? (req & mask_q) : req;
   assign cmd      = sync_q ? CMD_WR_IN : CMD_WR_UPD;

   rr_arbiter_6 #(
      .N  (NUM_CH),
      .IW (IDX_W)
   ) u_arb (
      .eligible (eligible),
      .ptr      (ptr_q),
      .grant    (arb_grant),
      .idx      (arb_idx),
      .valid    (arb_valid)
   );

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      mask_d        = mask_q;
      sync_d        = sync_q;
      ack_d         = '0;
      frame_valid_d = frame_valid_q;
      frame_data_d  = frame_data_q;
      ldac_cnt_d    = ldac_cnt_q;

      case (state_q)
         IDLE: begin
            if (|req) begin
               sync_d  = sync_mode;
               mask_d  = sync_mode ? req : '0;
               state_d = GRANT;
            end
         end

         GRANT: begin
            if (arb_valid) begin
               frame_data_d = {cmd, 4'(arb_idx), code_arr[arb_idx]};
               ack_d        = arb_grant;
               mask_d       = mask_q & ~arb_grant;
               ptr_d        = (arb_idx == IDX_W'(NUM_CH-1)) ? '0 : arb_idx + 1'b1;
               state_d      = SEND;
            end else if (sync_q) begin
               // Every snapshotted requester withdrew: still strobe LDAC.
               mask_d     = '0;
               ldac_cnt_d = 4'(LDAC_CYCLES-1);
               state_d    = LDAC;
            end else begin
               state_d = IDLE;
            end
         end

         SEND: begin
            // valid rises the cycle after ack; it drops right after the
            // handshake.
            if (frame_valid_q && frame_ready) begin
               frame_valid_d = 1'b0;
               state_d       = WAIT;
            end else begin
               frame_valid_d = 1'b1;
            end
         end

         WAIT: begin
            if (frame_done) begin
               if (sync_q) begin
                  if (|mask_q) begin
                     state_d = GRANT;
                  end else begin
                     ldac_cnt_d = 4'(LDAC_CYCLES-1);
                     state_d    = LDAC;
                  end
               end else begin
                  state_d = (|req) ? GRANT : IDLE;
               end
            end
         end

         LDAC: begin
            if (ldac_cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               ldac_cnt_d = ldac_cnt_q - 4'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         mask_q        <= '0;
         sync_q        <= 1'b0;
         ack_q         <= '0;
         frame_valid_q <= 1'b0;
         frame_data_q  <= '0;
         ldac_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         mask_q        <= mask_d;
         sync_q        <= sync_d;
         ack_q         <= ack_d;
         frame_valid_q <= frame_valid_d;
         frame_data_q  <= frame_data_d;
         ldac_cnt_q    <= ldac_cnt_d;
      end
   end

   assign ack         = ack_q;
   assign frame_valid = frame_valid_q;
   assign frame_data  = frame_data_q;
   assign ldac_n      = (state_q != LDAC);
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dac_ch_scheduler.sv
// Directed self-checking bench for dac_ch_scheduler. Expected frames are
// queued when requests are raised and compared at each serializer handshake.
module tb_dac_ch_scheduler;

   localparam int NCH  = 6;
   localparam int LDAC = 4;

   logic            sys_clk;
   logic            sys_rst_n;
   logic            sync_mode;
   logic [NCH-1:0]  req;
   logic [16*NCH-1:0] code;
   logic [NCH-1:0]  ack;
   logic            frame_valid;
   logic [23:0]     frame_data;
   logic            frame_ready;
   logic            frame_done;
   logic            ldac_n;
   logic            busy;

   int errors = 0;
   int checks = 0;
   logic [23:0] sb [$];

   dac_ch_scheduler #(
      .NUM_CH      (NCH),
      .LDAC_CYCLES (LDAC)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .sync_mode   (sync_mode),
      .req         (req),
      .code        (code),
      .ack         (ack),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_ready (frame_ready),
      .frame_done  (frame_done),
      .ldac_n      (ldac_n),
      .busy        (busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge sys_clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_code(input int ch, input logic [15:0] v);
      code[16*ch +: 16] = v;
   endtask

   // Acts as requester + serializer for the frame at the head of the queue:
   // waits for the ack, drops that req, holds ready low for ready_wait
   // cycles, accepts, compares, and optionally pulses frame_done.
   task automatic serve(input string tag, input int ready_wait, input bit do_done, output int lat);
      logic [23:0] exp, got;
      logic [2:0]  idx;
      bit          stable;
      lat = 0;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      exp = sb[0];
      idx = exp[18:16];
      while (ack === '0 && lat < 30) begin
         step();
         lat++;
      end
      check({tag, "_ack"}, 32'(ack), 32'(1) << idx);
      req[idx] = 1'b0;
      step();
      check({tag, "_valid"}, 32'(frame_valid), 32'd1);
      got    = frame_data;
      stable = 1'b1;
      for (int i = 0; i < ready_wait; i++) begin
         step();
         if (frame_valid !== 1'b1 || frame_data !== got || ack !== '0 || ldac_n !== 1'b1)
            stable = 1'b0;
      end
      check({tag, "_hold"}, 32'(stable), 32'd1);
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(frame_valid), 32'd0);
      void'(sb.pop_front());
      $display("frame %s: got=%h exp=%h", tag, got, exp);
      check({tag, "_frame"}, 32'(got), 32'(exp));
      if (do_done) begin
         repeat (3) step();
         frame_done = 1'b1;
         step();
         frame_done = 1'b0;
      end
   endtask

   // Called on the first cycle LDAC should be low; measures the pulse.
   task automatic ldac_check(input string tag);
      int n;
      bit quiet;
      n     = 0;
      quiet = 1'b1;
      while (ldac_n === 1'b0 && n < 40) begin
         if (ack !== '0 || frame_valid !== 1'b0) quiet = 1'b0;
         n++;
         step();
      end
      $display("ldac %s: low_cycles=%0d", tag, n);
      check({tag, "_ldac_len"}, 32'(n), 32'(LDAC));
      check({tag, "_ldac_quiet"}, 32'(quiet), 32'd1);
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      sys_rst_n   = 1'b0;
      sync_mode   = 1'b0;
      req         = '0;
      code        = '0;
      frame_ready = 1'b0;
      frame_done  = 1'b0;
      repeat (3) step();

      // Reset state
      check("rst_ack",   32'(ack),         32'd0);
      check("rst_valid", 32'(frame_valid), 32'd0);
      check("rst_data",  32'(frame_data),  32'd0);
      check("rst_ldac",  32'(ldac_n),      32'd1);
      check("rst_busy",  32'(busy),        32'd0);
      sys_rst_n = 1'b1;
      step();

      // Immediate mode, single channel
      set_code(2, 16'hABCD);
      req[2] = 1'b1;
      sb.push_back(24'h32ABCD);
      serve("imm2", 2, 1'b1, lat);
      check("imm2_latency", 32'(lat), 32'd2);
      check("imm2_idle", 32'(busy), 32'd0);

      // Backpressure for 10 cycles
      set_code(3, 16'h1234);
      req[3] = 1'b1;
      sb.push_back(24'h331234);
      serve("bp3", 10, 1'b1, lat);
      check("bp3_idle", 32'(busy), 32'd0);

      // All six from pointer 4: 4,5,0,1,2,3
      for (int i = 0; i < NCH; i++) set_code(i, 16'h1000 + 16'(i));
      req = '1;
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = (4 + k) % NCH;
         sb.push_back({4'h3, 4'(c), 16'h1000 + 16'(c)});
      end
      for (int k = 0; k < NCH; k++) serve("rr4", 1, 1'b1, lat);
      check("rr4_idle", 32'(busy), 32'd0);

      // Reset while waiting for frame_done
      set_code(5, 16'h5555);
      req[5] = 1'b1;
      sb.push_back(24'h355555);
      serve("wrst", 0, 1'b0, lat);
      step();
      sys_rst_n = 1'b0;
      step();
      check("wrst_busy",  32'(busy),        32'd0);
      check("wrst_ldac",  32'(ldac_n),      32'd1);
      check("wrst_valid", 32'(frame_valid), 32'd0);
      check("wrst_ack",   32'(ack),         32'd0);
      check("wrst_data",  32'(frame_data),  32'd0);
      sys_rst_n = 1'b1;
      step();

      // All six from pointer 0, req[0] re-asserted after its ack
      for (int i = 0; i < NCH; i++) set_code(i, 16'h2000 + 16'(i));
      req = '1;
      for (int k = 0; k < NCH; k++) sb.push_back({4'h3, 4'(k), 16'h2000 + 16'(k)});
      serve("rr0", 1, 1'b1, lat);
      set_code(0, 16'h0F0F);
      req[0] = 1'b1;
      sb.push_back(24'h300F0F);
      for (int k = 0; k < NCH; k++) serve("rr0", 1, 1'b1, lat);
      check("rr0_idle", 32'(busy), 32'd0);

      // Sync batch {1,4} with late requester 0
      sync_mode = 1'b1;
      set_code(1, 16'h1111);
      set_code(4, 16'h4444);
      req[1] = 1'b1;
      req[4] = 1'b1;
      sb.push_back(24'h111111);
      sb.push_back(24'h144444);
      serve("sync1", 1, 1'b1, lat);
      set_code(0, 16'h0AAA);
      req[0] = 1'b1;
      sb.push_back(24'h100AAA);
      serve("sync4", 1, 1'b1, lat);
      ldac_check("batch1");

      // Late requester forms the next batch; sync_mode flip mid-batch ignored
      step();
      sync_mode = 1'b0;
      serve("sync0", 1, 1'b1, lat);
      ldac_check("batch2");

      // Sync snapshot whose only requester withdraws before its grant
      sync_mode = 1'b1;
      req[3] = 1'b1;
      step();
      req[3] = 1'b0;
      step();
      ldac_check("empty");

      // Reset during the LDAC pulse
      set_code(2, 16'h2222);
      req[2] = 1'b1;
      sb.push_back(24'h122222);
      serve("lrst", 1, 1'b1, lat);
      step();
      check("lrst_in_ldac", 32'(ldac_n), 32'd0);
      sys_rst_n = 1'b0;
      step();
      check("lrst_ldac",  32'(ldac_n),      32'd1);
      check("lrst_busy",  32'(busy),        32'd0);
      check("lrst_ack",   32'(ack),         32'd0);
      check("lrst_valid", 32'(frame_valid), 32'd0);
      sys_rst_n = 1'b1;
      sync_mode = 1'b0;
      step();

      // Pointer restarted at 0: channel 2 before 5
      set_code(2, 16'hC002);
      set_code(5, 16'hC005);
      req[2] = 1'b1;
      req[5] = 1'b1;
      sb.push_back(24'h32C002);
      sb.push_back(24'h35C005);
      serve("ptr0", 1, 1'b1, lat);
      serve("ptr0", 1, 1'b1, lat);
      check("ptr0_idle", 32'(busy), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
